mult4x4_seq: RTL and testbench

- Unsigned sequential shift-add multiplier. Default operands are 4 bits and the product is 8 bits.
- Operands are captured on a start pulse. One multiplier bit is processed per clock cycle.
- The full-width product is presented on a registered output with a one-cycle done pulse.
- Used as a low-area arithmetic unit inside a clocked datapath; the controller issues start and waits for done.

---
 rtl/mult4x4_seq.sv | 105 ++++++++++
 tb/tb_mult4x4_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult4x4_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult4x4_seq
//  Description : Unsigned sequential shift-add multiplier. Operands are
//                captured on an accepted start. One multiplier bit is
//                processed per clock. The 2*WIDTH-bit product is presented
//                on a registered output, together with a one-cycle done pulse.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - synchronous active-low reset
//                start  - multiply request, sampled only while idle
//                A, B   - unsigned multiplicand / multiplier (WIDTH bits)
//                busy   - high while a multiply is in progress
//                done   - one-cycle pulse when M holds a new product
//                M      - registered product A*B (2*WIDTH bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult4x4_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   M
);

    localparam int              c_PW   = 2 * WIDTH;
    localparam int              c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [c_PW-1:0]  r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_PW-1:0]  r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [c_PW-1:0]  r_m;

    logic [c_PW-1:0]  w_addend;
    logic [c_PW-1:0]  w_sum;

    // Partial product for the current multiplier bit. Because the total
    // product never exceeds (2^WIDTH-1)^2, the sum stays within c_PW bits.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_m      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, A};
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (r_cnt == c_LAST) begin
                        // Last bit: publish the product directly from the
                        // adder. The accumulator itself is not needed again.
                        r_m     <= w_sum;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc    <= w_sum;
                        r_mcand  <= {r_mcand[c_PW-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        r_cnt    <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign M    = r_m;

endmodule
`default_nettype wire

// File: tb/tb_mult4x4_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult4x4_seq
//  Description : Self-checking bench for mult4x4_seq. A transaction-level
//                reference model (product = a*b, completion WIDTH edges after
//                the accept) is compared with busy/done/M every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult4x4_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] M;

    always #5 clk = ~clk;

    mult4x4_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .M     (M)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: cycles left in the current operation, the
    // product it will deliver, and the visible M/done values.
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_M    = '0;
    logic           m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample the driven inputs, advance the model across the edge,
    // then compare all outputs shortly after the edge.
    task automatic step();
        logic         r;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        r = rst_n;
        s = start;
        a = A;
        b = B;
        @(posedge clk);
        m_done = 1'b0;
        if (!r) begin
            m_left = 0;
            m_M    = '0;
        end else if (m_left == 0) begin
            if (s) begin
                m_left = W;
                m_prod = (2*W)'(a) * (2*W)'(b);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_M    = m_prod;
                m_done = 1'b1;
            end
        end
        #1;
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        check("M", 32'(M), 32'(m_M));
    endtask

    // Issue one multiply from idle and wait (bounded) for done. With junk=1
    // the operands and start are randomised while the unit is busy.
    task automatic run_op(input int a, input int b, input bit junk);
        bit seen;
        seen  = 1'b0;
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            if (junk) begin
                A     = W'($urandom);
                B     = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            step();
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 32'(0), 32'(1));
        check("product", 32'(M), 32'(a * b));
    endtask

    int da[6]   = '{10, 15, 15, 11, 15, 9};
    int db[6]   = '{10,  0, 15, 13,  9, 3};
    int dexp[6] = '{100, 0, 225, 143, 135, 27};

    initial begin
        int nd;
        rst_n = 1'b0;
        start = 1'b1;
        A     = 4'd15;
        B     = 4'd15;

        // Reset with start asserted: nothing may begin.
        step();
        step();
        rst_n = 1'b1;
        start = 1'b0;
        step();
        step();

        // Directed vectors with literal expected products.
        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], 1'b0);
            check("directed", 32'(M), 32'(dexp[i]));
            step();
        end

        // start pulsed while busy with other operands.
        A = 4'd11; B = 4'd13; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 4'd5; B = 4'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("busy_start_ignored", 32'(M), 32'(143));

        // Back-to-back with start held high.
        A = 4'd10; B = 4'd10; start = 1'b1;
        step();
        A = 4'd9; B = 4'd3;
        nd = 0;
        for (int i = 0; i < 30 && nd < 2; i++) begin
            step();
            if (done) begin
                nd++;
                if (nd == 1) check("b2b_first", 32'(M), 32'(100));
                else         check("b2b_second", 32'(M), 32'(27));
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(nd), 32'(2));
        step();
        step();

        // Reset two cycles into 15*15.
        A = 4'd15; B = 4'd15; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("abort_M", 32'(M), 32'(0));
        run_op(9, 3, 1'b0);

        // Exhaustive operand pairs, random idle gaps and random activity
        // while busy.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, 1'b1);
                for (int g = $urandom_range(0, 2); g > 0; g--) step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
